// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage MIPS pipeline: register Tuse/Tnew
// hazard detection plus the multi-cycle mult/div busy countdown.
module pipe_hazard_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic        rs_use_D,
  input  logic        rt_use_D,
  input  logic [1:0]  TuseRs_D,
  input  logic [1:0]  TuseRt_D,
  input  logic        md_use_D,
  input  logic [4:0]  regWA_E,
  input  logic        RegWrite_E,
  input  logic [1:0]  Tnew_E,
  input  logic [4:0]  regWA_M,
  input  logic        RegWrite_M,
  input  logic [1:0]  Tnew_M,
  input  logic        md_start_E,
  input  logic        md_is_div_E,
  output logic        en_pc,
  output logic        en01,
  output logic        en12,
  output logic        clr12,
  output logic        en23,
  output logic        en34,
  output logic        md_busy,
  output logic        md_done,
  output logic        md_err,
  output logic [31:0] stall_cnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic             md_done_q, md_done_d;
  logic             md_err_q, md_err_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;

  logic stall_rs, stall_rt, stall_md, stall, busy_int;

  assign busy_int = (md_cnt_q != '0);

  // A forward covers the hazard only when the producer is ready by the time the consumer needs it.
  always_comb begin
    stall_rs = rs_use_D && (rs_D != 5'd0) &&
               ((RegWrite_E && (regWA_E == rs_D) && (Tnew_E > TuseRs_D)) ||
                (RegWrite_M && (regWA_M == rs_D) && (Tnew_M > TuseRs_D)));
    stall_rt = rt_use_D && (rt_D != 5'd0) &&
               ((RegWrite_E && (regWA_E == rt_D) && (Tnew_E > TuseRt_D)) ||
                (RegWrite_M && (regWA_M == rt_D) && (Tnew_M > TuseRt_D)));
    stall_md = md_use_D && (busy_int || md_start_E);
    stall    = stall_rs || stall_rt || stall_md;
  end

  always_comb begin
    state_d   = state_q;
    md_cnt_d  = md_cnt_q;
    md_done_d = 1'b0;
    md_err_d  = md_err_q;
    case (state_q)
      IDLE: begin
        if (md_start_E) begin
          md_cnt_d = md_is_div_E ? DIV_CNT : MULT_CNT;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        md_cnt_d = md_cnt_q - CNT_ONE;
        if (md_cnt_q == CNT_ONE) begin
          md_done_d = 1'b1;
          state_d   = IDLE;
        end
        // A start while occupied is dropped; only the sticky error records it.
        if (md_start_E) md_err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    stall_cnt_d = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      md_cnt_q    <= '0;
      md_done_q   <= 1'b0;
      md_err_q    <= 1'b0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      md_done_q   <= md_done_d;
      md_err_q    <= md_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign en_pc     = reset || !stall;
  assign en01      = reset || !stall;
  assign clr12     = !reset && stall;
  assign en12      = 1'b1;
  assign en23      = 1'b1;
  assign en34      = 1'b1;
  assign md_busy   = !reset && busy_int;
  assign md_done   = !reset && md_done_q;
  assign md_err    = md_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage MIPS pipeline: IF, ID, EX, MEM, WB.
- Pipeline register names: IF/ID = 01, ID/EX = 12, EX/MEM = 23, MEM/WB = 34.
- Compares ID-stage source-register Tuse against EX/MEM-stage Tnew and freezes the front end when a forward cannot cover the hazard.
- Sequences the multi-cycle mult/div unit with a busy countdown, stalling ID-stage HI/LO/md users until the result is ready.
- Drives the enables and bubble-clear of every pipeline register and of the PC.

Parameters:
- MULT_LAT, 5, cycles mult/multu occupies the md unit.
- DIV_LAT, 10, cycles div/divu occupies the md unit; must be ≥ MULT_LAT and ≤ 15.
- CNT_W, 4, width of the md busy counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rs_D  in  5  ID-stage rs address.
- rt_D  in  5  ID-stage rt address.
- rs_use_D  in  1  ID instruction reads rs.
- rt_use_D  in  1  ID instruction reads rt.
- TuseRs_D  in  2  cycles until rs is needed (0..2).
- TuseRt_D  in  2  cycles until rt is needed (0..2).
- md_use_D  in  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo.
- regWA_E  in  5  EX-stage write address.
- RegWrite_E  in  1  EX-stage write enable.
- Tnew_E  in  2  EX-stage Tnew.
- regWA_M  in  5  MEM-stage write address.
- RegWrite_M  in  1  MEM-stage write enable.
- Tnew_M  in  2  MEM-stage Tnew.
- md_start_E  in  1  mult/div issuing in EX this cycle.
- md_is_div_E  in  1  1 = div/divu, 0 = mult/multu.
- en_pc  out  1  PC register enable.
- en01  out  1  IF/ID enable.
- en12  out  1  ID/EX enable.
- clr12  out  1  load a bubble (all-zero) into ID/EX.
- en23  out  1  EX/MEM enable.
- en34  out  1  MEM/WB enable.
- md_busy  out  1  md unit occupied.
- md_done  out  1  one-cycle pulse when the md result becomes valid.
- md_err  out  1  sticky flag: md_start_E was seen while busy.
- stall_cnt  out  32  count of stalled cycles, for performance.

Behaviour:
- State: md_cnt[CNT_W-1:0]; FSM states IDLE (md_cnt == 0) and BUSY (md_cnt != 0); md_err; stall_cnt.
- Reset (reset high at posedge clk): md_cnt ← 0, md_err ← 0, stall_cnt ← 0.
- While reset is high, outputs are forced to en_pc = en01 = en12 = en23 = en34 = 1, clr12 = 0, md_busy = 0, md_done = 0. Downstream registers then see their own reset with the enable high.
- Reset mid-operation aborts any md countdown with no md_done pulse.
- Register-hazard stall, combinational, same cycle. Per source s ∈ {rs, rt}:
  - stall_s = use_s & (s != 0) & [ (RegWrite_E & regWA_E == s & Tnew_E > Tuse_s) | (RegWrite_M & regWA_M == s & Tnew_M > Tuse_s) ].
  - Both comparisons are unsigned, 2-bit.
  - Writes to $0 never stall.
- md stall: stall_md = md_use_D & (md_busy | md_start_E).
- stall = stall_rs | stall_rt | stall_md.
- Outputs when stall = 1: en_pc = 0, en01 = 0, clr12 = 1.
- Outputs when stall = 0: en_pc = 1, en01 = 1, clr12 = 0.
- en12, en23 and en34 are always 1 outside reset. EX/MEM/WB always drain, so the bubble advances.
- md_busy = (md_cnt != 0).
- md FSM, IDLE:
  - md_start_E = 1 loads md_cnt ← MULT_LAT, or DIV_LAT if md_is_div_E = 1, and the FSM enters BUSY next cycle.
  - md_busy rises the cycle after the start.
- md FSM, BUSY:
  - md_cnt decrements by 1 each cycle.
  - On the transition 1→0, md_done = 1 for exactly the cycle in which md_cnt == 1 is being decremented (registered, visible in the cycle md_cnt reads 0). The FSM then returns to IDLE.
- md_start_E while BUSY: the start is ignored (counter unchanged) and md_err ← 1 until reset. This cannot happen in legal operation because of stall_md.
- Latency: an md user in ID directly behind a mult proceeds in the first cycle with md_busy = 0 and md_start_E = 0.
  - mult: MULT_LAT+1 stall cycles total (start cycle plus MULT_LAT busy cycles).
  - div: DIV_LAT+1 stall cycles.
- stall_cnt increments by 1 on every non-reset cycle with stall = 1 and wraps modulo 2^32.
- Simultaneous register and md stall causes a single stall; stall_cnt adds 1, not 2.

Test Plan:
- Load-use: lw writes $8 in EX (RegWrite_E = 1, regWA_E = 8, Tnew_E = 2); ID addu with rs_D = 8, TuseRs_D = 1 → stall: en_pc = 0, en01 = 0, clr12 = 1. Next cycle the lw is in MEM with Tnew_M = 1 → no stall. stall_cnt = 1.
- $0 write: RegWrite_E = 1, regWA_E = 0, Tnew_E = 2; rs_D = 0, rs_use_D = 1, TuseRs_D = 0 → no stall, en_pc = 1, clr12 = 0.
- Mult then mflo: md_start_E = 1, md_is_div_E = 0, while md_use_D = 1 held → exactly 6 stall cycles. md_busy is high for 5 cycles. md_done pulses once in the cycle md_cnt returns to 0. stall_cnt = 6.
- Div: md_is_div_E = 1 → md_busy high for 10 cycles; md_done pulses once. Raising md_start_E at busy cycle 3 → md_err = 1, count unaffected.
- Reset mid-div at busy cycle 4 → next cycle md_busy = 0, md_cnt = 0, md_err = 0, stall_cnt = 0, no md_done. During reset all enables read 1 and clr12 = 0.
- Dual hazard: rt hazard via MEM (Tnew_M = 1, TuseRt_D = 0) plus md_use_D with md_busy = 1 → stall = 1 and stall_cnt increments by exactly 1 per cycle.
